// File: rtl/cdb_arbiter_if.sv
// Requester result bus, CDB broadcast and per-queue occupancy between the functional units and the CDB arbiter.
// master drives results and observes the broadcast; slave is the arbiter side.
interface cdb_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int ROB_IDX_W = 5,
  parameter int DATA_W    = 32
);
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0][ROB_IDX_W-1:0] req_rob;
  logic [NUM_REQ-1:0][DATA_W-1:0]    req_data;
  logic [NUM_REQ-1:0]                req_ready;
  logic                              cdb_valid;
  logic [ROB_IDX_W-1:0]              cdb_rob;
  logic [DATA_W-1:0]                 cdb_data;
  logic [SRC_W-1:0]                  cdb_src;
  logic [NUM_REQ-1:0][1:0]           q_count;

  modport master (
    output req_valid, req_rob, req_data,
    input  req_ready, cdb_valid, cdb_rob, cdb_data, cdb_src, q_count
  );

  modport slave (
    input  req_valid, req_rob, req_data,
    output req_ready, cdb_valid, cdb_rob, cdb_data, cdb_src, q_count
  );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: per-requester 2-deep result queues, round-robin grant, registered broadcast; push-to-broadcast 2 cycles.
// req_ready falls only on a full queue (never on grant); flush discards every queued result.
module cdb_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ROB_IDX_W = 5,
  parameter int DATA_W    = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  cdb_arbiter_if.slave bus
);
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob;
    logic [DATA_W-1:0]    data;
  } entry_t;

  entry_t             mem [NUM_REQ][2];
  logic [1:0]         cnt [NUM_REQ];
  logic [NUM_REQ-1:0] rd_ptr;
  logic [NUM_REQ-1:0] wr_ptr;
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop;
  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   gnt_idx;
  logic [SRC_W-1:0]   idx;
  logic               gnt_vld;
  entry_t             head;

  always_comb begin
    push = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i] = (cnt[i] != 2'd2) && !rst;
      bus.q_count[i]   = cnt[i];
      push[i]          = bus.req_valid[i] && (cnt[i] != 2'd2) && !rst && !flush;
    end
  end

  // First non-empty queue at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = SRC_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!gnt_vld && cnt[idx] != 2'd0) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
    pop = '0;
    if (gnt_vld) pop[gnt_idx] = 1'b1;
    head = mem[gnt_idx][rd_ptr[gnt_idx]];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= '{rob: bus.req_rob[i], data: bus.req_data[i]};
    end
  end

  // One-bit pointers into a 2-entry queue simply toggle on each push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= 2'd0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= 2'd0;
    end else begin
      rd_ptr <= rd_ptr ^ pop;
      wr_ptr <= wr_ptr ^ push;
      for (int i = 0; i < NUM_REQ; i++) begin
        case ({push[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + 2'd1;
          2'b01:   cnt[i] <= cnt[i] - 2'd1;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr        <= '0;
      bus.cdb_valid <= 1'b0;
      bus.cdb_rob   <= '0;
      bus.cdb_data  <= '0;
      bus.cdb_src   <= '0;
    end else if (flush) begin
      rr_ptr        <= '0;
      bus.cdb_valid <= 1'b0;
    end else if (gnt_vld) begin
      rr_ptr        <= (gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0 : gnt_idx + SRC_W'(1);
      bus.cdb_valid <= 1'b1;
      bus.cdb_rob   <= head.rob;
      bus.cdb_data  <= head.data;
      bus.cdb_src   <= gnt_idx;
    end else begin
      bus.cdb_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a per-cycle vector table plus hand sequences for single push, flush and async reset.
module tb_cdb_arbiter;
  logic clk;
  logic rst;
  logic flush;
  int   n_cmp;
  int   n_err;

  cdb_arbiter_if #(.NUM_REQ(4), .ROB_IDX_W(5), .DATA_W(32)) bus ();

  cdb_arbiter #(.NUM_REQ(4), .ROB_IDX_W(5), .DATA_W(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      v;
    logic [3:0][4:0] rob;
    logic            e_vld;
    logic [4:0]      e_rob;
    logic [1:0]      e_src;
    logic [1:0]      e_rr;
    logic [7:0]      e_qc;
    logic [3:0]      e_rdy;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(logic [3:0] v, logic [19:0] rob, logic vld, logic [4:0] erob,
                              logic [1:0] esrc, logic [1:0] err, logic [7:0] qc, logic [3:0] rdy);
    vec_t r;
    r.v = v; r.rob = rob; r.e_vld = vld; r.e_rob = erob;
    r.e_src = esrc; r.e_rr = err; r.e_qc = qc; r.e_rdy = rdy;
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic [3:0] v, logic [19:0] rob);
    bus.req_valid = v;
    bus.req_rob   = rob;
    for (int i = 0; i < 4; i++) bus.req_data[i] = 32'hC0DE_0000 | 32'(bus.req_rob[i]);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    flush = 1'b0;
    drive(4'b0000, 20'd0);

    // Reset state
    step();
    chk("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
    chk("rst_cdb_rob", 64'(bus.cdb_rob), 64'd0);
    chk("rst_cdb_data", 64'(bus.cdb_data), 64'd0);
    chk("rst_cdb_src", 64'(bus.cdb_src), 64'd0);
    chk("rst_q_count", 64'(bus.q_count), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", 64'(bus.req_ready), 64'hF);

    // Single result from requester 2
    drive(4'b0100, {5'd0, 5'd5, 5'd0, 5'd0});
    bus.req_data[2] = 32'hDEAD_BEEF;
    step();
    drive(4'b0000, 20'd0);
    chk("single_wait_vld", 64'(bus.cdb_valid), 64'd0);
    chk("single_qc", 64'(bus.q_count), 64'h10);
    step();
    chk("single_vld", 64'(bus.cdb_valid), 64'd1);
    chk("single_rob", 64'(bus.cdb_rob), 64'd5);
    chk("single_data", 64'(bus.cdb_data), 64'hDEAD_BEEF);
    chk("single_src", 64'(bus.cdb_src), 64'd2);
    step();
    chk("single_after_vld", 64'(bus.cdb_valid), 64'd0);

    rst = 1'b1;
    #1;
    rst = 1'b0;

    // Simultaneous requests, then wrap, then backpressure on requester 1
    tbl[0]  = mk(4'b1111, {5'd3, 5'd2, 5'd1, 5'd0},  1'b0, 5'd0,  2'd0, 2'd0, 8'b01010101, 4'b1111);
    tbl[1]  = mk(4'b0000, 20'd0,                     1'b1, 5'd0,  2'd0, 2'd1, 8'b01010100, 4'b1111);
    tbl[2]  = mk(4'b0000, 20'd0,                     1'b1, 5'd1,  2'd1, 2'd2, 8'b01010000, 4'b1111);
    tbl[3]  = mk(4'b0000, 20'd0,                     1'b1, 5'd2,  2'd2, 2'd3, 8'b01000000, 4'b1111);
    tbl[4]  = mk(4'b0000, 20'd0,                     1'b1, 5'd3,  2'd3, 2'd0, 8'b00000000, 4'b1111);
    tbl[5]  = mk(4'b0000, 20'd0,                     1'b0, 5'd3,  2'd3, 2'd0, 8'b00000000, 4'b1111);
    tbl[6]  = mk(4'b0100, {5'd0, 5'd10, 5'd0, 5'd0}, 1'b0, 5'd3,  2'd3, 2'd0, 8'b00010000, 4'b1111);
    tbl[7]  = mk(4'b1001, {5'd20, 5'd0, 5'd0, 5'd21}, 1'b1, 5'd10, 2'd2, 2'd3, 8'b01000001, 4'b1111);
    tbl[8]  = mk(4'b1001, {5'd22, 5'd0, 5'd0, 5'd23}, 1'b1, 5'd20, 2'd3, 2'd0, 8'b01000010, 4'b1110);
    tbl[9]  = mk(4'b0000, 20'd0,                     1'b1, 5'd21, 2'd0, 2'd1, 8'b01000001, 4'b1111);
    tbl[10] = mk(4'b0000, 20'd0,                     1'b1, 5'd22, 2'd3, 2'd0, 8'b00000001, 4'b1111);
    tbl[11] = mk(4'b0000, 20'd0,                     1'b1, 5'd23, 2'd0, 2'd1, 8'b00000000, 4'b1111);
    tbl[12] = mk(4'b0000, 20'd0,                     1'b0, 5'd23, 2'd0, 2'd1, 8'b00000000, 4'b1111);
    tbl[13] = mk(4'b0011, {5'd0, 5'd0, 5'd11, 5'd1}, 1'b0, 5'd23, 2'd0, 2'd1, 8'b00000101, 4'b1111);
    tbl[14] = mk(4'b0011, {5'd0, 5'd0, 5'd12, 5'd2}, 1'b1, 5'd11, 2'd1, 2'd2, 8'b00000110, 4'b1110);
    tbl[15] = mk(4'b0010, {5'd0, 5'd0, 5'd13, 5'd0}, 1'b1, 5'd1,  2'd0, 2'd1, 8'b00001001, 4'b1101);
    tbl[16] = mk(4'b0011, {5'd0, 5'd0, 5'd14, 5'd3}, 1'b1, 5'd12, 2'd1, 2'd2, 8'b00000110, 4'b1110);
    tbl[17] = mk(4'b0010, {5'd0, 5'd0, 5'd14, 5'd0}, 1'b1, 5'd2,  2'd0, 2'd1, 8'b00001001, 4'b1101);
    tbl[18] = mk(4'b0000, 20'd0,                     1'b1, 5'd13, 2'd1, 2'd2, 8'b00000101, 4'b1111);
    tbl[19] = mk(4'b0000, 20'd0,                     1'b1, 5'd3,  2'd0, 2'd1, 8'b00000100, 4'b1111);
    tbl[20] = mk(4'b0000, 20'd0,                     1'b1, 5'd14, 2'd1, 2'd2, 8'b00000000, 4'b1111);
    tbl[21] = mk(4'b0000, 20'd0,                     1'b0, 5'd14, 2'd1, 2'd2, 8'b00000000, 4'b1111);

    for (int r = 0; r < 22; r++) begin
      drive(tbl[r].v, tbl[r].rob);
      step();
      chk($sformatf("row%0d_vld", r), 64'(bus.cdb_valid), 64'(tbl[r].e_vld));
      chk($sformatf("row%0d_rob", r), 64'(bus.cdb_rob), 64'(tbl[r].e_rob));
      chk($sformatf("row%0d_src", r), 64'(bus.cdb_src), 64'(tbl[r].e_src));
      chk($sformatf("row%0d_rr", r), 64'(dut.rr_ptr), 64'(tbl[r].e_rr));
      chk($sformatf("row%0d_qc", r), 64'(bus.q_count), 64'(tbl[r].e_qc));
      chk($sformatf("row%0d_rdy", r), 64'(bus.req_ready), 64'(tbl[r].e_rdy));
      if (tbl[r].e_vld)
        chk($sformatf("row%0d_data", r), 64'(bus.cdb_data), 64'(32'hC0DE_0000 | 32'(tbl[r].e_rob)));
    end

    // Flush with five results queued and a push on requester 3 in the flush cycle
    drive(4'b1111, {5'd24, 5'd25, 5'd26, 5'd27});
    step();
    chk("fl_fill_qc", 64'(bus.q_count), 64'b01010101);
    drive(4'b0011, {5'd0, 5'd0, 5'd28, 5'd29});
    step();
    chk("fl_pre_qc", 64'(bus.q_count), 64'b01001010);
    chk("fl_pre_src", 64'(bus.cdb_src), 64'd2);
    drive(4'b1000, {5'd31, 5'd0, 5'd0, 5'd0});
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(4'b0000, 20'd0);
    chk("fl_vld", 64'(bus.cdb_valid), 64'd0);
    chk("fl_qc", 64'(bus.q_count), 64'd0);
    chk("fl_rr", 64'(dut.rr_ptr), 64'd0);
    for (int c = 0; c < 6; c++) begin
      step();
      chk($sformatf("fl_quiet%0d", c), 64'(bus.cdb_valid), 64'd0);
    end

    // Asynchronous reset while a broadcast is live and queues are occupied
    drive(4'b1111, {5'd1, 5'd2, 5'd3, 5'd4});
    step();
    drive(4'b0000, 20'd0);
    step();
    chk("ar_pre_vld", 64'(bus.cdb_valid), 64'd1);
    chk("ar_pre_rob", 64'(bus.cdb_rob), 64'd4);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_vld", 64'(bus.cdb_valid), 64'd0);
    chk("ar_rdy", 64'(bus.req_ready), 64'd0);
    chk("ar_rob", 64'(bus.cdb_rob), 64'd0);
    chk("ar_data", 64'(bus.cdb_data), 64'd0);
    chk("ar_src", 64'(bus.cdb_src), 64'd0);
    chk("ar_qc", 64'(bus.q_count), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("ar_post_rdy", 64'(bus.req_ready), 64'hF);
    for (int c = 0; c < 6; c++) begin
      step();
      chk($sformatf("ar_quiet%0d", c), 64'(bus.cdb_valid), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
